pb_ddr_mailbox: RTL
===================

# pb_ddr_mailbox

Port-mapped responder on the PicoBlaze (KCPSM3) I/O bus that lets firmware drive the DDR manager. Firmware writes address/data/command registers with OUTPUT instructions. The block issues a single-beat DDR command through a valid/ready handshake and buffers returned read data in a small FIFO for INPUT instructions. It raises and holds `interrupt` until KCPSM3 acknowledges it.

## Interface
- `BASE_ADDR`, default 8'h00: port_id of register 0. The block decodes `BASE_ADDR`..`BASE_ADDR+8`.
- `RFIFO_DEPTH`, default 4: read-data FIFO entries. Must be a power of 2, ≥2.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-low reset.
- `port_id`  in  8  KCPSM3 port address. Stable for both cycles of an INPUT/OUTPUT instruction.
- `write_strobe`  in  1  one-cycle OUTPUT qualifier.
- `read_strobe`  in  1  one-cycle INPUT qualifier. Used only for read side effects (FIFO pop).
- `out_port`  in  8  write data from KCPSM3.
- `in_port`  out  8  registered read mux to KCPSM3.
- `interrupt`  out  1  level interrupt request to KCPSM3.
- `interrupt_ack`  in  1  one-cycle acknowledge from KCPSM3.
- `cmd_valid`  out  1  DDR command request.
- `cmd_ready`  in  1  DDR manager accepts the command when `cmd_valid` and `cmd_ready` are both high.
- `cmd_we`  out  1  1 = write, 0 = read.
- `cmd_addr`  out  24  word address.
- `cmd_wdata`  out  16  write data.
- `rd_valid`  in  1  one-cycle read-data strobe from the DDR manager.
- `rd_data`  in  16  read data, qualified by `rd_valid`.

## Operation
- Register map, as offset from `BASE_ADDR`:
  - 0–2 ADDR0..ADDR2: R/W, `cmd_addr[7:0]`, `[15:8]`, `[23:16]`.
  - 3–4 WDATA_L/H: R/W, `cmd_wdata`.
  - 5 CMD/STATUS:
    - Write: bit0 = we, and the write launches a command.
    - Read: {3'b0, irq_pend, err, ovf, full, busy}.
  - 6 RDATA_L: R, FIFO head `[7:0]`, no pop.
  - 7 RDATA_H: R, FIFO head `[15:8]`. `read_strobe` on this port pops the FIFO if it is not empty.
  - 8 IRQ:
    - Write: bit0 = irq_en; bit1 = 1 clears err and ovf (write-1-to-clear).
    - Read: {6'b0, empty, irq_en}.
  - Unmapped `port_id`: `in_port` reads 8'h00. Writes to unmapped or read-only ports are ignored.
- Command FSM:
  - IDLE: a CMD write latches `cmd_we` and goes to ISSUE.
  - ISSUE: `cmd_valid` = 1. Addr/data/we are held constant while in ISSUE.
    - On handshake with `cmd_we` = 1, go to IDLE.
    - On handshake with `cmd_we` = 0, go to WAIT_RD.
  - WAIT_RD: the first `rd_valid` pushes `rd_data` and returns to IDLE.
  - busy = (state ≠ IDLE).
  - A CMD write while busy is ignored and sets sticky err.
  - Writes to ADDR/WDATA while busy update the registers. `cmd_addr`/`cmd_wdata` outputs come from launch-time copies.
- Read FIFO:
  - Push on any `rd_valid`.
  - When full, the push is dropped and sticky ovf is set.
  - A push and a pop in the same cycle are both performed when non-empty: the count is unchanged, and this holds even at full.
  - When empty, RDATA reads return 8'h00.
- Interrupt:
  - irq_pend is set when irq_en = 1 and either a write command is accepted or a read push occurs (including a dropped push).
  - irq_pend is cleared by `interrupt_ack`.
  - `interrupt` = irq_pend.
  - Set and ack in the same cycle leaves irq_pend = 1.
  - Clearing irq_en does not clear irq_pend.

## Timing
- Reset (`reset` = 0 at a clock edge) gives:
  - All registers 0, FSM IDLE, FIFO empty.
  - `cmd_valid` = 0, `cmd_we` = 0, `cmd_addr` = 0, `cmd_wdata` = 0.
  - `in_port` = 0, `interrupt` = 0.
- Reset mid-command drops the command and the FIFO contents. A later `rd_valid` is pushed normally.
- Register writes take effect on the edge where `write_strobe` is high. A CMD write makes `cmd_valid` = 1 on the next cycle.
- `cmd_valid` is never deasserted before the handshake, except by reset.
- `in_port` is registered from `port_id` every cycle, so it has 1-cycle latency. It is valid in the second instruction cycle, when KCPSM3 samples it.
- A pop takes effect on the `read_strobe` edge. The popped value is the one already presented on `in_port`.
- The status bits in `in_port` reflect state registered one cycle earlier.
- Minimum write turnaround: CMD write → handshake → IDLE takes 2 cycles with `cmd_ready` tied high.

## Test plan
- Reset check: hold `reset` = 0 for 2 cycles with strobes active → all outputs 0 and a STATUS read returns 8'h00.
- Write command: write ADDR = 24'h123456, WDATA = 16'hBEEF, CMD = 8'h01, with `cmd_ready` delayed 3 cycles → `cmd_valid` high for exactly 4 cycles with `cmd_we` = 1, addr 24'h123456, data 16'hBEEF; busy = 1 until the handshake.
- Read command: CMD = 8'h00, `cmd_ready` = 1, `rd_valid` with 16'hA55A 5 cycles later → RDATA_L = 8'h5A, RDATA_H = 8'hA5; after the pop, empty = 1.
- FIFO overflow: 5 pushes with depth 4 and no pops → full = 1, ovf = 1, head = first value. IRQ write of 8'h02 clears ovf.
- Interrupt: irq_en = 1, complete a write, assert `interrupt_ack` in the same cycle as a new read push → `interrupt` stays 1; a second ack clears it.
- Busy error: a CMD write during WAIT_RD → no second `cmd_valid`, err = 1; unmapped port 8'hF0 reads 8'h00.

Source files
------------

// File: rtl/pb_ddr_mailbox.sv
// KCPSM3 port-mapped mailbox in front of the DDR manager: register file,
// single-beat command issue, a small read-data FIFO and a level interrupt.
module pb_ddr_mailbox #(
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter int         RFIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  port_id,
  input  logic        write_strobe,
  input  logic        read_strobe,
  input  logic [7:0]  out_port,
  output logic [7:0]  in_port,
  output logic        interrupt,
  input  logic        interrupt_ack,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_we,
  output logic [23:0] cmd_addr,
  output logic [15:0] cmd_wdata,
  input  logic        rd_valid,
  input  logic [15:0] rd_data
);

  localparam int PTR_W = (RFIFO_DEPTH > 1) ? $clog2(RFIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RFIFO_DEPTH);

  localparam logic [7:0] OFS_ADDR0   = 8'd0;
  localparam logic [7:0] OFS_ADDR1   = 8'd1;
  localparam logic [7:0] OFS_ADDR2   = 8'd2;
  localparam logic [7:0] OFS_WDATA_L = 8'd3;
  localparam logic [7:0] OFS_WDATA_H = 8'd4;
  localparam logic [7:0] OFS_CMD     = 8'd5;
  localparam logic [7:0] OFS_RDATA_L = 8'd6;
  localparam logic [7:0] OFS_RDATA_H = 8'd7;
  localparam logic [7:0] OFS_IRQ     = 8'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD
  } state_t;

  state_t state_reg, state_next;

  logic [7:0]  addr0_reg, addr1_reg, addr2_reg;
  logic [7:0]  wdata_l_reg, wdata_h_reg;
  logic        cmd_we_reg;
  logic [23:0] cmd_addr_reg;
  logic [15:0] cmd_wdata_reg;
  logic        err_reg, ovf_reg, irq_en_reg, irq_pend_reg;
  logic [7:0]  in_port_reg, in_port_next;

  logic [15:0]      fifo_mem [RFIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic [7:0]  offset;
  logic        mapped, wr_en, cmd_wr, busy;
  logic        launch, handshake;
  logic        empty, full, pop, push, drop;
  logic        irq_set, irq_clr;
  logic [15:0] head;

  // Offset arithmetic wraps in 8 bits, so one compare decodes the window.
  assign offset  = port_id - BASE_ADDR;
  assign mapped  = (offset <= OFS_IRQ);
  assign wr_en   = write_strobe && mapped;
  assign cmd_wr  = wr_en && (offset == OFS_CMD);
  assign busy    = (state_reg != ST_IDLE);
  assign irq_clr = wr_en && (offset == OFS_IRQ) && out_port[1];

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_CNT);
  assign pop   = read_strobe && mapped && (offset == OFS_RDATA_H) && !empty;
  assign push  = rd_valid && (!full || pop);
  assign drop  = rd_valid && full && !pop;
  assign head  = empty ? 16'h0000 : fifo_mem[rd_ptr_reg];

  assign irq_set = irq_en_reg && ((handshake && cmd_we_reg) || rd_valid);

  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    handshake  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_wr) begin
          launch     = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          handshake  = 1'b1;
          state_next = cmd_we_reg ? ST_IDLE : ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (rd_valid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_port_next = 8'h00;
    if (mapped) begin
      case (offset)
        OFS_ADDR0:   in_port_next = addr0_reg;
        OFS_ADDR1:   in_port_next = addr1_reg;
        OFS_ADDR2:   in_port_next = addr2_reg;
        OFS_WDATA_L: in_port_next = wdata_l_reg;
        OFS_WDATA_H: in_port_next = wdata_h_reg;
        OFS_CMD:     in_port_next = {3'b000, irq_pend_reg, err_reg, ovf_reg, full, busy};
        OFS_RDATA_L: in_port_next = head[7:0];
        OFS_RDATA_H: in_port_next = head[15:8];
        OFS_IRQ:     in_port_next = {6'b000000, empty, irq_en_reg};
        default:     in_port_next = 8'h00;
      endcase
    end
  end

  // Storage is left unreset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= rd_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      addr0_reg     <= 8'h00;
      addr1_reg     <= 8'h00;
      addr2_reg     <= 8'h00;
      wdata_l_reg   <= 8'h00;
      wdata_h_reg   <= 8'h00;
      cmd_we_reg    <= 1'b0;
      cmd_addr_reg  <= 24'h000000;
      cmd_wdata_reg <= 16'h0000;
      err_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      irq_en_reg    <= 1'b0;
      irq_pend_reg  <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      in_port_reg   <= 8'h00;
    end else begin
      state_reg   <= state_next;
      in_port_reg <= in_port_next;

      if (wr_en) begin
        case (offset)
          OFS_ADDR0:   addr0_reg   <= out_port;
          OFS_ADDR1:   addr1_reg   <= out_port;
          OFS_ADDR2:   addr2_reg   <= out_port;
          OFS_WDATA_L: wdata_l_reg <= out_port;
          OFS_WDATA_H: wdata_h_reg <= out_port;
          OFS_IRQ:     irq_en_reg  <= out_port[0];
          default:     ;
        endcase
      end

      // Launch-time copies keep the command stable while firmware preloads the next one.
      if (launch) begin
        cmd_we_reg    <= out_port[0];
        cmd_addr_reg  <= {addr2_reg, addr1_reg, addr0_reg};
        cmd_wdata_reg <= {wdata_h_reg, wdata_l_reg};
      end

      if (cmd_wr && busy) err_reg <= 1'b1;
      else if (irq_clr)   err_reg <= 1'b0;

      if (drop)         ovf_reg <= 1'b1;
      else if (irq_clr) ovf_reg <= 1'b0;

      if (irq_set)            irq_pend_reg <= 1'b1;
      else if (interrupt_ack) irq_pend_reg <= 1'b0;

      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign in_port   = in_port_reg;
  assign interrupt = irq_pend_reg;
  assign cmd_valid = (state_reg == ST_ISSUE);
  assign cmd_we    = cmd_we_reg;
  assign cmd_addr  = cmd_addr_reg;
  assign cmd_wdata = cmd_wdata_reg;

endmodule
